// File: rtl/shift_register_piso_tx.sv
// Parallel-in/serial-out transmitter: takes an N-bit word on a valid/ready
// handshake and shifts it out one bit per clock with a qualifying strobe.
module shift_register_piso_tx #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] PI,
  output logic         SO,
  output logic         so_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           accept;
  logic [N-1:0]   sreg_shifted;

  // Final bit of the word in flight is on the line this cycle
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  // Ready may only look at reset and state, never at PI/load_valid
  assign load_ready = !reset && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  // Shift toward the output end with zero fill
  assign sreg_shifted = MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // Covers both a fresh load from IDLE and a back-to-back reload
      state <= SHIFT;
      sreg  <= PI;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sreg <= sreg_shifted;
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Outputs decode registered state only; the line idles low
  assign SO       = (state == SHIFT) && (MSB_FIRST ? sreg[N-1] : sreg[0]);
  assign so_valid = (state == SHIFT);
  assign busy     = (state == SHIFT);
  assign done     = last_bit;

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Directed bench for shift_register_piso_tx: MSB-first and LSB-first instances,
// expected serial bits queued at each intended accept and checked per cycle.
module tb_shift_register_piso_tx;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pi;
  logic         lv_m, lr_m, so_m, sv_m, busy_m, done_m;
  logic         lv_l, lr_l, so_l, sv_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  logic [1:0]   q_m[$];
  logic [1:0]   q_l[$];
  logic [N-1:0] po_m;
  int           vcnt_m;

  always #5 clk = ~clk;

  shift_register_piso_tx #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(lv_m), .load_ready(lr_m), .PI(pi),
    .SO(so_m), .so_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  shift_register_piso_tx #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_valid(lv_l), .load_ready(lr_l), .PI(pi),
    .SO(so_l), .so_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {SO, done} sequence for one word
  task automatic push_word(input logic [N-1:0] w, input bit msb, input bit to_m);
    logic [1:0] e;
    for (int i = 0; i < int'(N); i++) begin
      e[1] = msb ? w[N-1-i] : w[i];
      e[0] = (i == int'(N) - 1);
      if (to_m) q_m.push_back(e);
      else      q_l.push_back(e);
    end
  endtask

  // Drive a word that the bench expects to be accepted at the next edge
  task automatic accept_m(input logic [N-1:0] w);
    pi = w; lv_m = 1'b1;
    #1 chk("m_ready_at_load", 32'(lr_m), 32'd1);
    @(posedge clk);
    push_word(w, 1'b1, 1'b1);
    #1 lv_m = 1'b0; pi = '0;
  endtask

  task automatic accept_l(input logic [N-1:0] w);
    pi = w; lv_l = 1'b1;
    #1 chk("l_ready_at_load", 32'(lr_l), 32'd1);
    @(posedge clk);
    push_word(w, 1'b0, 1'b0);
    #1 lv_l = 1'b0; pi = '0;
  endtask

  task automatic chk_idle_m(input string tag);
    chk({tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({tag, "_ready"}, 32'(lr_m), 32'd1);
    chk({tag, "_qleft"}, 32'(q_m.size()), 32'd0);
  endtask

  // Monitor: pop one expected bit per valid cycle, idle line otherwise
  always @(negedge clk) begin
    logic [1:0] e;
    if (sv_m) begin
      if (q_m.size() == 0) chk("m_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q_m.pop_front();
        chk("m_so", 32'(so_m), 32'(e[1]));
        chk("m_done", 32'(done_m), 32'(e[0]));
        chk("m_busy", 32'(busy_m), 32'd1);
        po_m = {po_m[N-2:0], so_m};
        vcnt_m++;
      end
    end else begin
      chk("m_gap", 32'(q_m.size()), 32'd0);
      chk("m_idle_so", 32'(so_m), 32'd0);
      chk("m_idle_done", 32'(done_m), 32'd0);
      chk("m_idle_busy", 32'(busy_m), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (sv_l) begin
      if (q_l.size() == 0) chk("l_spurious_valid", 32'd1, 32'd0);
      else begin
        e = q_l.pop_front();
        chk("l_so", 32'(so_l), 32'(e[1]));
        chk("l_done", 32'(done_l), 32'(e[0]));
        chk("l_busy", 32'(busy_l), 32'd1);
      end
    end else begin
      chk("l_gap", 32'(q_l.size()), 32'd0);
      chk("l_idle_so", 32'(so_l), 32'd0);
      chk("l_idle_done", 32'(done_l), 32'd0);
      chk("l_idle_busy", 32'(busy_l), 32'd0);
    end
  end

  initial begin
    reset = 1'b1; lv_m = 1'b0; lv_l = 1'b0; pi = '0;
    po_m = '0; vcnt_m = 0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1 chk("rst_ready_m", 32'(lr_m), 32'd0);
    chk("rst_ready_l", 32'(lr_l), 32'd0);
    chk("rst_so_m", 32'(so_m), 32'd0);
    chk("rst_valid_m", 32'(sv_m), 32'd0);
    reset = 1'b0;
    #1 chk("rel_ready_m", 32'(lr_m), 32'd1);
    chk("rel_ready_l", 32'(lr_l), 32'd1);
    @(posedge clk); #1;

    // MSB-first 8'hC1, loopback into a modelled SIPO
    po_m = '0;
    accept_m(8'hC1);
    repeat (8) @(posedge clk);
    #1 chk_idle_m("msb_c1");
    chk("msb_c1_loopback", 32'(po_m), 32'h0C1);

    // LSB-first 8'hC1
    accept_l(8'hC1);
    repeat (8) @(posedge clk);
    #1 chk("lsb_c1_busy", 32'(busy_l), 32'd0);
    chk("lsb_c1_qleft", 32'(q_l.size()), 32'd0);

    // Back-to-back C1 then 3C: 16 contiguous valid cycles
    vcnt_m = 0;
    accept_m(8'hC1);
    repeat (7) @(posedge clk);
    #1 accept_m(8'h3C);
    repeat (8) @(posedge clk);
    #1 chk_idle_m("b2b");
    chk("b2b_valid_cycles", 32'(vcnt_m), 32'd16);

    // Load attempt mid-word is ignored
    accept_m(8'hC1);
    repeat (2) @(posedge clk);
    #1 pi = 8'hFF; lv_m = 1'b1;
    #1 chk("midword_ready", 32'(lr_m), 32'd0);
    @(posedge clk);
    #1 lv_m = 1'b0; pi = '0;
    repeat (5) @(posedge clk);
    #1 chk_idle_m("ignored_load");

    // Reset in cycle 4 aborts the word without a done pulse
    accept_m(8'hC1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_ready", 32'(lr_m), 32'd0);
    @(posedge clk);
    q_m.delete();
    #1 reset = 1'b0;
    chk("abort_valid", 32'(sv_m), 32'd0);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_done", 32'(done_m), 32'd0);
    #1 chk("abort_ready_rel", 32'(lr_m), 32'd1);
    @(posedge clk); #1;
    po_m = '0;
    accept_m(8'h3C);
    repeat (8) @(posedge clk);
    #1 chk_idle_m("post_abort");
    chk("post_abort_loopback", 32'(po_m), 32'h03C);

    repeat (2) @(posedge clk);
    #1 chk("final_q_m", 32'(q_m.size()), 32'd0);
    chk("final_q_l", 32'(q_l.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
